// File: rtl/conv_window_scheduler_if.sv
// rtl/conv_window_scheduler_if.sv - operand-issue and result-return bus between scheduler and MAC datapath

interface conv_window_scheduler_if #(
  parameter int ADDR_W = 12
);
  logic              op_valid;
  logic              op_ready;
  logic [ADDR_W-1:0] k_addr;
  logic [ADDR_W-1:0] x_addr;
  logic              op_first;
  logic              op_last;
  logic              res_valid;
  logic [ADDR_W-1:0] res_idx;

  modport master (
    output op_valid, k_addr, x_addr, op_first, op_last, res_idx,
    input  op_ready, res_valid
  );

  modport slave (
    input  op_valid, k_addr, x_addr, op_first, op_last, res_idx,
    output op_ready, res_valid
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - walks convolution windows and kernel taps, issuing address pairs to the MAC datapath

module conv_window_scheduler #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIM_W-1:0]            cfg_m,
  input  logic [DIM_W-1:0]            cfg_n,
  input  logic [DIM_W-1:0]            cfg_s,
  input  logic [DIM_W-1:0]            cfg_l,
  input  logic [DIM_W-1:0]            cfg_w,
  conv_window_scheduler_if.master     bus,
  output logic                        busy,
  output logic                        done,
  output logic                        invalid_operation
);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DRAIN, FIN} state_t;

  localparam int EXT_W  = DIM_W + 2;
  localparam int PROD_W = 2 * DIM_W;

  state_t state, state_nxt;

  logic [DIM_W-1:0]  m_r, n_r, s_r, l_r, w_r;
  logic [DIM_W-1:0]  i_r, j_r;
  logic [DIM_W-1:0]  col_base, row_base;
  logic [ADDR_W-1:0] k_r;
  logic [ADDR_W-1:0] row_off;       // (row_base + i) * W, stepped by W per kernel row
  logic [ADDR_W-1:0] row_base_off;  // row_base * W, stepped by S*W per output row
  logic [ADDR_W-1:0] stride_off;    // S * W, formed once while the configuration is checked
  logic [ADDR_W-1:0] issued;
  logic [ADDR_W-1:0] received;
  logic              inv_r;

  logic              cfg_ok;
  logic              accept;
  logic              tap_j_end, tap_i_end, last_tap;
  logic              col_wrap, row_done;
  logic              count_res;
  logic [ADDR_W-1:0] recv_total;
  logic [PROD_W-1:0] stride_full;

  assign cfg_ok = (m_r != '0) && (n_r != '0) && (s_r != '0) && (l_r != '0) && (w_r != '0) &&
                  (m_r <= l_r) && (n_r <= w_r) && (m_r == n_r) && (l_r == w_r);

  assign accept    = (state == ISSUE) && bus.op_ready;
  assign tap_j_end = (j_r == n_r - DIM_W'(1));
  assign tap_i_end = (i_r == m_r - DIM_W'(1));
  assign last_tap  = tap_i_end && tap_j_end;

  // Window-fit tests use the pre-advance base, widened so base+S+size cannot wrap.
  assign col_wrap = ({2'b00, col_base} + {2'b00, s_r} + {2'b00, n_r}) > EXT_W'(w_r);
  assign row_done = ({2'b00, row_base} + {2'b00, s_r} + {2'b00, m_r}) > EXT_W'(l_r);

  assign count_res  = bus.res_valid && ((state == ISSUE) || (state == DRAIN));
  assign recv_total = received + ADDR_W'(bus.res_valid);

  assign stride_full = {{DIM_W{1'b0}}, s_r} * {{DIM_W{1'b0}}, w_r};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: state_nxt = cfg_ok ? ISSUE : IDLE;
      ISSUE: if (accept && last_tap && col_wrap && row_done) state_nxt = DRAIN;
      DRAIN: if (recv_total == issued) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; address registers are zero in reset so outputs clear asynchronously.
  always_comb begin
    bus.op_valid      = (state == ISSUE);
    bus.op_first      = (state == ISSUE) && (i_r == '0) && (j_r == '0);
    bus.op_last       = (state == ISSUE) && last_tap;
    bus.k_addr        = k_r;
    bus.x_addr        = row_off + ADDR_W'(col_base) + ADDR_W'(j_r);
    bus.res_idx       = received;
    busy              = (state != IDLE);
    done              = (state == FIN);
    invalid_operation = inv_r;
  end

  // Configuration latch, tap/window counters and result counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_r          <= '0;
      n_r          <= '0;
      s_r          <= '0;
      l_r          <= '0;
      w_r          <= '0;
      i_r          <= '0;
      j_r          <= '0;
      col_base     <= '0;
      row_base     <= '0;
      k_r          <= '0;
      row_off      <= '0;
      row_base_off <= '0;
      stride_off   <= '0;
      issued       <= '0;
      received     <= '0;
      inv_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_r          <= cfg_m;
            n_r          <= cfg_n;
            s_r          <= cfg_s;
            l_r          <= cfg_l;
            w_r          <= cfg_w;
            i_r          <= '0;
            j_r          <= '0;
            col_base     <= '0;
            row_base     <= '0;
            k_r          <= '0;
            row_off      <= '0;
            row_base_off <= '0;
            stride_off   <= '0;
            issued       <= '0;
            received     <= '0;
            inv_r        <= 1'b0;
          end
        end
        CHECK: begin
          stride_off <= ADDR_W'(stride_full);
          if (!cfg_ok) inv_r <= 1'b1;
        end
        ISSUE: begin
          if (accept) begin
            if (last_tap) begin
              i_r    <= '0;
              j_r    <= '0;
              k_r    <= '0;
              issued <= issued + ADDR_W'(1);
              if (col_wrap) begin
                col_base     <= '0;
                row_base     <= row_base + s_r;
                row_base_off <= row_base_off + stride_off;
                row_off      <= row_base_off + stride_off;
              end else begin
                col_base <= col_base + s_r;
                row_off  <= row_base_off;
              end
            end else if (tap_j_end) begin
              j_r     <= '0;
              i_r     <= i_r + DIM_W'(1);
              k_r     <= k_r + ADDR_W'(1);
              row_off <= row_off + ADDR_W'(w_r);
            end else begin
              j_r <= j_r + DIM_W'(1);
              k_r <= k_r + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (count_res) received <= received + ADDR_W'(1);
    end
  end

endmodule
